// File: rtl/player_life_ctrl_pkg.sv
// Shared definitions for the player life controller: state encoding, spawn point, overlap test.
// The spawn point is also used by player_state; keep both in sync.
package player_life_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd1;
    localparam logic [2:0] ST_HIT      = 3'd2;
    localparam logic [2:0] ST_RESPAWN  = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    localparam logic [15:0] SPAWN_X = 16'd315;
    localparam logic [15:0] SPAWN_Y = 16'd344;

    typedef enum logic [2:0] {
        StIdle     = ST_IDLE,
        StPlay     = ST_PLAY,
        StHit      = ST_HIT,
        StRespawn  = ST_RESPAWN,
        StGameover = ST_GAMEOVER
    } state_e;

    // Sums are widened to 17 bits so a box near the screen edge cannot wrap.
    function automatic logic boxes_overlap(
        input logic [15:0] ax,
        input logic [15:0] ay,
        input logic [15:0] bx,
        input logic [15:0] by,
        input logic [16:0] aw,
        input logic [16:0] ah,
        input logic [16:0] bw,
        input logic [16:0] bh
    );
        logic [16:0] ax_w, ay_w, bx_w, by_w;
        ax_w = {1'b0, ax};
        ay_w = {1'b0, ay};
        bx_w = {1'b0, bx};
        by_w = {1'b0, by};
        return (ax_w < bx_w + bw) && (bx_w < ax_w + aw) &&
               (ay_w < by_w + bh) && (by_w < ay_w + ah);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter that steps once per frame pulse and holds at zero.
// A load takes priority over a frame pulse in the same cycle.
module frame_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] din,
    input  logic         frame,
    output logic [W-1:0] q,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = din;
        end else if (frame && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q    = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/player_life_ctrl.sv
// Game-flow controller: per-frame hazard overlap check, life counting, freeze/respawn control.
// Optional post-respawn grace period is enabled by defining PLAYER_LIFE_INVULN_EN.
module player_life_ctrl
    import player_life_ctrl_pkg::*;
#(
    parameter int unsigned LIVES         = 3,
    parameter int unsigned PW            = 16,
    parameter int unsigned PH            = 16,
    parameter int unsigned HW            = 16,
    parameter int unsigned HH            = 16,
    parameter int unsigned HIT_FRAMES    = 60,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned FLASH_DIV     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame,
    input  logic        start,
    input  logic [15:0] px,
    input  logic [15:0] py,
    input  logic [15:0] hx,
    input  logic [15:0] hy,
    output logic        game,
    output logic        resetp,
    output logic [3:0]  lives,
    output logic        flash,
    output logic        over
);

    localparam logic [3:0] LivesInit  = 4'(LIVES);
    localparam logic [7:0] HitLoad    = 8'(HIT_FRAMES);
    localparam logic [7:0] GraceLoad  = 8'(INVULN_FRAMES);
    localparam logic [7:0] FlashLast  = 8'(FLASH_DIV - 1);

    if (LIVES < 1 || LIVES > 15 || HIT_FRAMES < 1 || HIT_FRAMES > 255 ||
        INVULN_FRAMES > 255 || FLASH_DIV < 1 || FLASH_DIV > 256) begin : g_param_check
        $error("player_life_ctrl: parameter out of range");
    end

    state_e      state_q, state_d;
    logic [3:0]  lives_q, lives_d;
    logic        resetp_q, resetp_d;
    logic        flash_q, flash_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;

    logic        overlap;
    logic        hit_ld;
    logic        hit_zero;
    logic        grace_clr;
    logic        grace_zero;
    logic        flash_active;
    logic [7:0]  unused_hit_q;

    assign overlap = boxes_overlap(px, py, hx, hy, 17'(PW), 17'(PH), 17'(HW), 17'(HH));

    frame_timer #(
        .W (8)
    ) u_hit_timer (
        .clk   (clk),
        .reset (reset),
        .ld    (hit_ld),
        .din   (HitLoad),
        .frame (frame && (state_q == StHit)),
        .q     (unused_hit_q),
        .zero  (hit_zero)
    );

`ifdef PLAYER_LIFE_INVULN_EN
    logic [7:0] unused_grace_q;

    // Start clears any leftover grace; respawn arms a fresh one.
    frame_timer #(
        .W (8)
    ) u_grace_timer (
        .clk   (clk),
        .reset (reset),
        .ld    (grace_clr || (state_q == StRespawn)),
        .din   (grace_clr ? 8'd0 : GraceLoad),
        .frame (frame && (state_q == StPlay)),
        .q     (unused_grace_q),
        .zero  (grace_zero)
    );

    assign flash_active = (state_q == StHit) || ((state_q == StPlay) && !grace_zero);
`else
    logic       unused_grace_clr;
    logic [7:0] unused_grace_load;

    assign unused_grace_clr  = grace_clr;
    assign unused_grace_load = GraceLoad;
    assign grace_zero        = 1'b1;
    assign flash_active      = (state_q == StHit);
`endif

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        resetp_d  = 1'b0;
        hit_ld    = 1'b0;
        grace_clr = 1'b0;
        unique case (state_q)
            StIdle, StGameover: begin
                if (start) begin
                    state_d   = StPlay;
                    lives_d   = LivesInit;
                    resetp_d  = 1'b1;
                    grace_clr = 1'b1;
                end
            end
            StPlay: begin
                if (frame && overlap && grace_zero) begin
                    state_d = StHit;
                    lives_d = lives_q - 1'b1;
                    hit_ld  = 1'b1;
                end
            end
            StHit: begin
                if (hit_zero) begin
                    if (lives_q == 4'd0) begin
                        state_d = StGameover;
                    end else begin
                        state_d  = StRespawn;
                        resetp_d = 1'b1;
                    end
                end
            end
            StRespawn: begin
                state_d = StPlay;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        if (!flash_active) begin
            flash_d     = 1'b0;
            flash_cnt_d = 8'd0;
        end else if (frame) begin
            if (flash_cnt_q == FlashLast) begin
                flash_cnt_d = 8'd0;
                flash_d     = !flash_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            lives_q     <= LivesInit;
            resetp_q    <= 1'b0;
            flash_q     <= 1'b0;
            flash_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            resetp_q    <= resetp_d;
            flash_q     <= flash_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    // Gating with flash_active drops the blink the same cycle the state leaves HIT/grace.
    assign flash  = flash_q && flash_active;
    assign game   = (state_q != StPlay);
    assign resetp = resetp_q;
    assign lives  = lives_q;
    assign over   = (state_q == StGameover);

endmodule

// File: tb/tb_player_life_ctrl.sv
// Directed self-checking bench for player_life_ctrl with hand-computed expectations.
module tb_player_life_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame;
    logic        start;
    logic [15:0] px, py, hx, hy;
    logic        game;
    logic        resetp;
    logic [3:0]  lives;
    logic        flash;
    logic        over;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    player_life_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .frame  (frame),
        .start  (start),
        .px     (px),
        .py     (py),
        .hx     (hx),
        .hy     (hy),
        .game   (game),
        .resetp (resetp),
        .lives  (lives),
        .flash  (flash),
        .over   (over)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick();
    endtask

    // Hit from PLAY with the hazard overlapping, then ride out the full HIT period.
    task automatic run_hit(input logic [3:0] exp_lives, input logic exp_over);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_eq("hit_game", 32'(game), 32'd1);
        check_eq("hit_lives", 32'(lives), 32'(exp_lives));
        for (int i = 0; i < 60; i++) begin
            frame_pulse();
            if (i == 7)  check_eq("flash_on_8", 32'(flash), 32'd1);
            if (i == 15) check_eq("flash_off_16", 32'(flash), 32'd0);
            if (i == 55) check_eq("flash_on_56", 32'(flash), 32'd1);
        end
        check_eq("exit_resetp", 32'(resetp), 32'(!exp_over));
        check_eq("exit_over", 32'(over), 32'(exp_over));
        check_eq("exit_game", 32'(game), 32'd1);
        check_eq("exit_flash", 32'(flash), 32'd0);
        if (!exp_over) begin
            tick();
            check_eq("respawn_resetp_off", 32'(resetp), 32'd0);
            check_eq("respawn_game", 32'(game), 32'd0);
        end
    endtask

    task automatic ride_grace(input logic [3:0] exp_lives);
`ifdef PLAYER_LIFE_INVULN_EN
        for (int i = 0; i < 120; i++) begin
            frame_pulse();
        end
        check_eq("grace_lives", 32'(lives), 32'(exp_lives));
        check_eq("grace_game", 32'(game), 32'd0);
`else
        check_eq("no_grace_lives", 32'(lives), 32'(exp_lives));
`endif
    endtask

    initial begin
        reset = 1'b1;
        frame = 1'b0;
        start = 1'b0;
        px = 16'd0;
        py = 16'd0;
        hx = 16'd0;
        hy = 16'd0;
        repeat (3) tick();
        check_eq("rst_game", 32'(game), 32'd1);
        check_eq("rst_resetp", 32'(resetp), 32'd0);
        check_eq("rst_lives", 32'(lives), 32'd3);
        check_eq("rst_over", 32'(over), 32'd0);
        check_eq("rst_flash", 32'(flash), 32'd0);
        reset = 1'b0;

        frame_pulse();
        check_eq("idle_frame_game", 32'(game), 32'd1);

        // Start and frame together with overlap: start wins, no hit.
        start = 1'b1;
        frame = 1'b1;
        tick();
        start = 1'b0;
        frame = 1'b0;
        check_eq("start_resetp", 32'(resetp), 32'd1);
        check_eq("start_game", 32'(game), 32'd0);
        check_eq("start_lives", 32'(lives), 32'd3);
        tick();
        check_eq("start_resetp_off", 32'(resetp), 32'd0);
        check_eq("start_game_hold", 32'(game), 32'd0);

        // Edge-touching boxes do not overlap.
        px = 16'd100; py = 16'd100; hx = 16'd116; hy = 16'd100;
        frame_pulse();
        check_eq("touch_right_lives", 32'(lives), 32'd3);
        check_eq("touch_right_game", 32'(game), 32'd0);
        px = 16'd100; py = 16'd100; hx = 16'd100; hy = 16'd116;
        frame_pulse();
        check_eq("touch_below_lives", 32'(lives), 32'd3);
        px = 16'd116; py = 16'd100; hx = 16'd100; hy = 16'd100;
        frame_pulse();
        check_eq("touch_left_lives", 32'(lives), 32'd3);
        px = 16'hfff8; py = 16'd100; hx = 16'd4; hy = 16'd100;
        frame_pulse();
        check_eq("no_wrap_lives", 32'(lives), 32'd3);

        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("play_start_ignored", 32'(resetp), 32'd0);
        check_eq("play_start_game", 32'(game), 32'd0);

        px = 16'd100; py = 16'd100; hx = 16'd110; hy = 16'd110;
        overlap_no_frame: begin
            tick();
            check_eq("overlap_no_frame", 32'(lives), 32'd3);
        end
        run_hit(4'd2, 1'b0);
        ride_grace(4'd2);
        run_hit(4'd1, 1'b0);
        ride_grace(4'd1);
        run_hit(4'd0, 1'b1);
        check_eq("over_lives", 32'(lives), 32'd0);
        frame_pulse();
        check_eq("over_hold", 32'(over), 32'd1);

        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_lives", 32'(lives), 32'd3);
        check_eq("restart_resetp", 32'(resetp), 32'd1);
        check_eq("restart_over", 32'(over), 32'd0);
        check_eq("restart_game", 32'(game), 32'd0);
        tick();

        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_eq("mid_hit_lives", 32'(lives), 32'd2);
        for (int i = 0; i < 30; i++) begin
            frame_pulse();
        end
        check_eq("mid_hit_flash", 32'(flash), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_game", 32'(game), 32'd1);
        check_eq("mid_rst_lives", 32'(lives), 32'd3);
        check_eq("mid_rst_flash", 32'(flash), 32'd0);
        check_eq("mid_rst_over", 32'(over), 32'd0);
        check_eq("mid_rst_resetp", 32'(resetp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
